// File: rtl/trace_recorder_pkg.sv
// trace_recorder_pkg: shared types and constants for the trace recorder.
//   state_t   - capture FSM states (3-bit encoding)
//   DEF_*     - default parameter values
//   entry_w() - width of one ring-buffer entry; includes the CNT_W-bit cycle
//               stamp only when TRACE_TIMESTAMP_EN is defined
package trace_recorder_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      FILL = 3'd1,
      WAIT = 3'd2,
      POST = 3'd3,
      DUMP = 3'd4
   } state_t;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 16;
   localparam int DEF_PRE   = 4;
   localparam int DEF_CNT_W = 32;

`ifdef TRACE_TIMESTAMP_EN
   localparam bit STAMP_EN = 1'b1;
`else
   localparam bit STAMP_EN = 1'b0;
`endif

   function automatic int entry_w(input int width, input int cnt_w);
      return STAMP_EN ? width + cnt_w : width;
   endfunction

endpackage

// File: rtl/trace_recorder_if.sv
// trace_recorder_if: probe/trigger inputs and readout stream of the recorder.
//   arm, probe, trig          - capture control and sampled vector
//   done                      - high while the window is being drained
//   rd_valid/rd_ready/rd_data - readout stream, rd_last marks the final beat
//   cycle                     - free-running cycle count
// Modports: master = harness side, slave = recorder side.
interface trace_recorder_if
   import trace_recorder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
);
   localparam int EW = entry_w(WIDTH, CNT_W);

   logic             arm;
   logic [WIDTH-1:0] probe;
   logic             trig;
   logic             done;
   logic             rd_valid;
   logic             rd_ready;
   logic [EW-1:0]    rd_data;
   logic             rd_last;
   logic [CNT_W-1:0] cycle;

   modport master (
      output arm, probe, trig, rd_ready,
      input  done, rd_valid, rd_data, rd_last, cycle
   );

   modport slave (
      input  arm, probe, trig, rd_ready,
      output done, rd_valid, rd_data, rd_last, cycle
   );

endinterface

// File: rtl/trace_ring_buf.sv
// trace_ring_buf: DEPTH-entry ring buffer with its own write/read pointers.
//   clock, reset - clock and async active-high reset (pointers only)
//   wr_clr       - restart the write pointer at 0
//   wr_en/wr_data- store an entry at wr_ptr and advance it (mod DEPTH)
//   rd_load      - set rd_ptr to (rd_base - PRE) mod DEPTH
//   rd_inc       - advance rd_ptr (mod DEPTH)
//   wr_ptr       - current write pointer
//   rd_data      - combinational read of the entry at rd_ptr
module trace_ring_buf #(
   parameter int DEPTH = 16,
   parameter int EW    = 8,
   parameter int PRE   = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     wr_clr,
   input  logic                     wr_en,
   input  logic [EW-1:0]            wr_data,
   input  logic                     rd_load,
   input  logic [$clog2(DEPTH)-1:0] rd_base,
   input  logic                     rd_inc,
   output logic [$clog2(DEPTH)-1:0] wr_ptr,
   output logic [EW-1:0]            rd_data
);
   localparam int PW = $clog2(DEPTH);

   // DEPTH is a power of two, so PW-bit pointer arithmetic wraps mod DEPTH.
   logic [EW-1:0] mem [DEPTH];
   logic [PW-1:0] rd_ptr;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_clr)
            wr_ptr <= '0;
         else if (wr_en)
            wr_ptr <= wr_ptr + PW'(1);

         if (rd_load)
            rd_ptr <= rd_base - PW'(PRE);
         else if (rd_inc)
            rd_ptr <= rd_ptr + PW'(1);
      end
   end

   // Storage is intentionally not reset.
   always_ff @(posedge clock) begin
      if (wr_en)
         mem[wr_ptr] <= wr_data;
   end

   assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/trace_recorder.sv
// trace_recorder: captures a DEPTH-sample window of a probe vector around a
// trigger (PRE samples before it) and drains it over a valid/ready stream.
//   clock, reset - clock and async active-high reset
//   bus (slave)  - arm/probe/trig inputs, done + rd_* readout, cycle count
// Build option: TRACE_TIMESTAMP_EN adds the cycle count at write time to each
// entry; rd_data then carries {stamp, probe}.
//
// state | meaning
// IDLE  | waiting for arm
// FILL  | collecting the PRE pre-trigger samples
// WAIT  | ring running freely, waiting for trig
// POST  | collecting the DEPTH-PRE-1 post-trigger samples
// DUMP  | draining the window, oldest sample first
module trace_recorder
   import trace_recorder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int PRE   = DEF_PRE,
   parameter int CNT_W = DEF_CNT_W
) (
   input logic           clock,
   input logic           reset,
   trace_recorder_if.slave bus
);
   localparam int            PW        = $clog2(DEPTH);
   localparam int            EW        = entry_w(WIDTH, CNT_W);
   localparam int            POST_N    = DEPTH - PRE - 1;
   localparam logic [PW-1:0] LAST_BEAT = PW'(DEPTH - 1);

   state_t           state;
   logic [PW-1:0]    fill_cnt;
   logic [PW-1:0]    post_cnt;
   logic [PW-1:0]    beat;
   logic [PW-1:0]    trig_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_base;
   logic [CNT_W-1:0] cycle_q;
   logic             dump_q;
   logic             wr_en, wr_clr, rd_load, rd_inc;
   logic [EW-1:0]    wr_data, rd_entry;

   assign wr_clr  = (state == IDLE) && bus.arm;
   assign wr_en   = (state == FILL) || (state == WAIT) || (state == POST);
   // Enter DUMP either straight from the trigger (no post samples) or on
   // the last post write; trig_ptr is not registered yet in the first case.
   assign rd_load = ((state == WAIT) && bus.trig && (POST_N == 0)) ||
                    ((state == POST) && (post_cnt == PW'(1)));
   assign rd_base = (state == WAIT) ? wr_ptr : trig_ptr;
   assign rd_inc  = (state == DUMP) && dump_q && bus.rd_ready;

`ifdef TRACE_TIMESTAMP_EN
   assign wr_data = {cycle_q, bus.probe};
`else
   assign wr_data = bus.probe;
`endif

   trace_ring_buf #(
      .DEPTH (DEPTH),
      .EW    (EW),
      .PRE   (PRE)
   ) u_ring (
      .clock   (clock),
      .reset   (reset),
      .wr_clr  (wr_clr),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .rd_load (rd_load),
      .rd_base (rd_base),
      .rd_inc  (rd_inc),
      .wr_ptr  (wr_ptr),
      .rd_data (rd_entry)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         fill_cnt <= '0;
         post_cnt <= '0;
         beat     <= '0;
         trig_ptr <= '0;
         dump_q   <= 1'b0;
         cycle_q  <= '0;
      end else begin
         cycle_q <= cycle_q + CNT_W'(1);
         unique case (state)
            IDLE: begin
               if (bus.arm) begin
                  fill_cnt <= PW'((PRE == 0) ? 0 : PRE - 1);
                  state    <= (PRE == 0) ? WAIT : FILL;
               end
            end
            FILL: begin
               if (fill_cnt == '0)
                  state <= WAIT;
               else
                  fill_cnt <= fill_cnt - PW'(1);
            end
            WAIT: begin
               if (bus.trig) begin
                  trig_ptr <= wr_ptr;
                  post_cnt <= PW'(POST_N);
                  if (POST_N == 0) begin
                     state  <= DUMP;
                     beat   <= '0;
                     dump_q <= 1'b1;
                  end else begin
                     state <= POST;
                  end
               end
            end
            POST: begin
               post_cnt <= post_cnt - PW'(1);
               if (post_cnt == PW'(1)) begin
                  state  <= DUMP;
                  beat   <= '0;
                  dump_q <= 1'b1;
               end
            end
            DUMP: begin
               if (dump_q && bus.rd_ready) begin
                  beat <= beat + PW'(1);
                  if (beat == LAST_BEAT) begin
                     state  <= IDLE;
                     dump_q <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.done     = dump_q;
   assign bus.rd_valid = dump_q;
   assign bus.rd_data  = dump_q ? rd_entry : '0;
   assign bus.rd_last  = dump_q && (beat == LAST_BEAT);
   assign bus.cycle    = cycle_q;

endmodule
